perceptron_core: RTL and testbench
==================================

// Module: perceptron_core
// PURPOSE
//  Parametrised single-neuron perceptron. Computes y = (sum_i w_i*x_i + b >= 0) over N_INPUTS signed inputs.
//  Uses one sequential multiply-accumulate per cycle. Optional on-chip perceptron-rule training.
//  Sits between the input capture logic and the LED/output stage of perceptron_top; replaces the fixed 2-input neuron.
// PARAMETERS
//  N_INPUTS   4   number of inputs/weights (>=1)
//  DATA_W     8   signed input width
//  WEIGHT_W   8   signed weight and bias width
//  ACC_W      20  signed accumulator width; sum_o width
//  LR_SHIFT   0   learning rate = 2^-LR_SHIFT; the weight step is x_i >>> LR_SHIFT
// PORTS
//  clk_i      in   1                  clock; all logic on rising edge
//  reset_i    in   1                  synchronous, active-high reset
//  x_valid_i  in   1                  input vector valid
//  x_ready_o  out  1                  core idle, will accept the vector
//  x_i        in   N_INPUTS*DATA_W    packed signed inputs; x[0] in LSBs
//  train_i    in   1                  sampled with the vector; 1 = apply learning rule
//  target_i   in   1                  sampled with the vector; desired class
//  y_valid_o  out  1                  result valid
//  y_ready_i  in   1                  consumer accepts the result
//  y_o        out  1                  classification
//  sum_o      out  ACC_W              signed pre-activation sum
//  w_wr_i     in   1                  weight write strobe
//  w_addr_i   in   $clog2(N_INPUTS+1) index 0..N_INPUTS-1 = w_i; N_INPUTS = bias
//  w_data_i   in   WEIGHT_W           signed write data
//  busy_o     out  1                  high in any state but IDLE
// BEHAVIOUR
//  Reset: all weights/bias=0; state IDLE; x_ready_o=1; y_valid_o=0; y_o=0; sum_o=0; busy_o=0.
//  FSM IDLE->MAC->ACT->[UPDATE]->OUT->IDLE.
//  IDLE: x_ready_o=1. On x_valid_i, latch x_i, train_i and target_i. Load acc = sign-extended bias. Go to MAC, idx=0.
//  MAC: one cycle per input. acc += w[idx]*x[idx] (full-precision signed product, sign-extended).
//    The add saturates at +/-(2^(ACC_W-1)-1 / -2^(ACC_W-1)). After idx=N_INPUTS-1, go to ACT.
//  ACT: y = ~acc[ACC_W-1], so acc=0 gives 1. sum_o = acc. err = target - y.
//    err=0 or train=0: go to OUT. Otherwise go to UPDATE.
//  UPDATE: N_INPUTS+1 cycles, one weight per cycle, bias last.
//    w_i += err*(x_i>>>LR_SHIFT); bias += err. Each add saturates to WEIGHT_W.
//  OUT: y_valid_o=1, with y_o/sum_o stable until y_valid_o&&y_ready_i. Then go to IDLE.
//  Latency, accept edge to y_valid_o: N_INPUTS+2 cycles without update; 2*N_INPUTS+3 with update.
//  Back-pressure: OUT holds indefinitely; no new vector is accepted while busy.
//  Weight writes: honoured only in IDLE. In IDLE, a write and an accept on the same cycle both take effect.
//    The write lands first, so the bias write is visible in the accumulator init.
//    w_wr_i outside IDLE is dropped. Addresses > N_INPUTS are ignored.
//  y_o/sum_o keep their last values after the OUT handshake until the next ACT.
//  reset_i mid-operation: next cycle is IDLE with reset values. Weights are cleared and the in-flight result is discarded.
// CONFIGURATION
//  PERCEPTRON_TRAIN_EN defined: UPDATE state and learning-rule datapath present, as above.
//  PERCEPTRON_TRAIN_EN undefined: train_i/target_i ignored; ACT always goes to OUT.
//    Latency is always N_INPUTS+2. Weights change only via w_wr_i.
// TESTING
//  1 Reset, N=4: write w=[1,2,3,4], b=-10. x=[1,1,1,1] -> y_o=1, sum_o=0, y_valid_o 6 cycles after accept.
//  2 Same weights, x=[-1,0,0,0] -> y_o=0, sum_o=-11. Hold y_ready_i=0 for 5 cycles.
//    y_valid_o/y_o/sum_o stay stable; x_ready_o stays 0.
//  3 TRAIN_EN: all weights 0, x=[2,-3,0,1], train=1, target=0 -> y=1, err=-1.
//    Weights become [-2,3,0,-1], bias=-1. Latency 11. Repeat -> y_o=0, no update.
//  4 Saturation, DATA_W=WEIGHT_W=8, ACC_W=16: w_i=127, x_i=127, N=4 -> sum_o=32767.
//    With w=127, target=0 training on x=127 repeatedly -> no weight wraps past -128.
//  5 Assert w_wr_i during MAC -> weight unchanged. Assert reset_i in MAC -> IDLE next cycle, weights 0, y_valid_o=0.
//  6 Without TRAIN_EN: train=1, target=0, y=1 -> weights unchanged, latency 6.

Source files
------------

// File: rtl/perceptron_core_if.sv
// Handshake, result and weight-write bundle for perceptron_core.
// slave = core side, master = driver side.
interface perceptron_core_if #(
  parameter int N_INPUTS = 4,
  parameter int DATA_W   = 8,
  parameter int WEIGHT_W = 8,
  parameter int ACC_W    = 20
);
  localparam int ADDR_W = $clog2(N_INPUTS + 1);

  logic                       x_valid_i;
  logic                       x_ready_o;
  logic [N_INPUTS*DATA_W-1:0] x_i;
  logic                       train_i;
  logic                       target_i;
  logic                       y_valid_o;
  logic                       y_ready_i;
  logic                       y_o;
  logic signed [ACC_W-1:0]    sum_o;
  logic                       w_wr_i;
  logic [ADDR_W-1:0]          w_addr_i;
  logic signed [WEIGHT_W-1:0] w_data_i;
  logic                       busy_o;

  modport slave (
    input  x_valid_i, x_i, train_i, target_i,
    input  y_ready_i, w_wr_i, w_addr_i, w_data_i,
    output x_ready_o, y_valid_o, y_o, sum_o, busy_o
  );

  modport master (
    output x_valid_i, x_i, train_i, target_i,
    output y_ready_i, w_wr_i, w_addr_i, w_data_i,
    input  x_ready_o, y_valid_o, y_o, sum_o, busy_o
  );
endinterface

// File: rtl/perceptron_core.sv
// Sequential single-neuron perceptron, one MAC per cycle.
// Define PERCEPTRON_TRAIN_EN to build in perceptron-rule training.
module perceptron_core #(
  parameter int N_INPUTS = 4,
  parameter int DATA_W   = 8,
  parameter int WEIGHT_W = 8,
  parameter int ACC_W    = 20,
  parameter int LR_SHIFT = 0
) (
  input logic              clk_i,
  input logic              reset_i,
  perceptron_core_if.slave bus
);
  localparam int ADDR_W = $clog2(N_INPUTS + 1);
  localparam int PROD_W = DATA_W + WEIGHT_W;
  localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
  localparam int UPD_W  = ((DATA_W > WEIGHT_W) ? DATA_W : WEIGHT_W) + 2;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_INPUTS);

  localparam logic signed [SUM_W-1:0] ACC_MAX =
    SUM_W'({1'b0, {(ACC_W-1){1'b1}}});
  localparam logic signed [SUM_W-1:0] ACC_MIN = -ACC_MAX - 1'b1;

  typedef enum logic [2:0] {IDLE, MAC, ACT, UPDATE, OUT} state_t;

  state_t                     state;
  logic [ADDR_W-1:0]          idx;
  logic signed [WEIGHT_W-1:0] w_q [N_INPUTS+1];
  logic signed [DATA_W-1:0]   x_q [N_INPUTS+1];
  logic signed [ACC_W-1:0]    acc;
  logic signed [PROD_W-1:0]   prod;
  logic                       y_q;
  logic signed [ACC_W-1:0]    sum_q;
  logic                       y_valid_q;
  logic                       x_ready_q;
  logic                       busy_q;

  logic signed [WEIGHT_W-1:0] w_cur;
  logic signed [DATA_W-1:0]   x_cur;
  logic signed [PROD_W-1:0]   prod_c;
  logic signed [SUM_W-1:0]    acc_sum;
  logic signed [ACC_W-1:0]    acc_sat;
  logic signed [WEIGHT_W-1:0] bias_init;
  logic                       wr_ok;
  logic                       y_next;

  assign bus.x_ready_o = x_ready_q;
  assign bus.y_valid_o = y_valid_q;
  assign bus.y_o       = y_q;
  assign bus.sum_o     = sum_q;
  assign bus.busy_o    = busy_q;

  assign wr_ok  = bus.w_wr_i && (bus.w_addr_i <= LAST);
  assign y_next = ~acc[ACC_W-1];

  // A same-cycle bias write must already be seen by the accumulator init.
  assign bias_init = (bus.w_wr_i && bus.w_addr_i == LAST) ?
                     bus.w_data_i : w_q[N_INPUTS];

  // Product is registered, so the add lags the multiply by one cycle.
  always_comb begin
    w_cur   = w_q[idx];
    x_cur   = x_q[idx];
    prod_c  = PROD_W'(w_cur) * PROD_W'(x_cur);
    acc_sum = SUM_W'(acc) + SUM_W'(prod);
    if (acc_sum > ACC_MAX)
      acc_sat = ACC_MAX[ACC_W-1:0];
    else if (acc_sum < ACC_MIN)
      acc_sat = ACC_MIN[ACC_W-1:0];
    else
      acc_sat = acc_sum[ACC_W-1:0];
  end

`ifdef PERCEPTRON_TRAIN_EN
  localparam logic signed [UPD_W-1:0] W_MAX =
    UPD_W'({1'b0, {(WEIGHT_W-1){1'b1}}});
  localparam logic signed [UPD_W-1:0] W_MIN = -W_MAX - 1'b1;

  logic                       train_q;
  logic                       target_q;
  logic signed [UPD_W-1:0]    step;
  logic signed [UPD_W-1:0]    w_sum;
  logic signed [WEIGHT_W-1:0] w_new;

  // err is +/-1; y_q=1 means target was 0, so the step is subtracted.
  always_comb begin
    if (idx == LAST)
      step = {{(UPD_W-1){1'b0}}, 1'b1};
    else
      step = UPD_W'(x_cur) >>> LR_SHIFT;
    w_sum = y_q ? (UPD_W'(w_cur) - step) : (UPD_W'(w_cur) + step);
    if (w_sum > W_MAX)
      w_new = W_MAX[WEIGHT_W-1:0];
    else if (w_sum < W_MIN)
      w_new = W_MIN[WEIGHT_W-1:0];
    else
      w_new = w_sum[WEIGHT_W-1:0];
  end
`else
  logic unused_train;
  assign unused_train = ^{bus.train_i, bus.target_i, LR_SHIFT[0]};
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state     <= IDLE;
      idx       <= '0;
      acc       <= '0;
      prod      <= '0;
      y_q       <= 1'b0;
      sum_q     <= '0;
      y_valid_q <= 1'b0;
      x_ready_q <= 1'b1;
      busy_q    <= 1'b0;
      for (int i = 0; i <= N_INPUTS; i++) begin
        w_q[i] <= '0;
        x_q[i] <= '0;
      end
`ifdef PERCEPTRON_TRAIN_EN
      train_q  <= 1'b0;
      target_q <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (wr_ok)
            w_q[bus.w_addr_i] <= bus.w_data_i;
          if (bus.x_valid_i) begin
            for (int i = 0; i < N_INPUTS; i++)
              x_q[i] <= bus.x_i[i*DATA_W +: DATA_W];
`ifdef PERCEPTRON_TRAIN_EN
            train_q  <= bus.train_i;
            target_q <= bus.target_i;
`endif
            acc       <= ACC_W'(bias_init);
            prod      <= '0;
            idx       <= '0;
            x_ready_q <= 1'b0;
            busy_q    <= 1'b1;
            state     <= MAC;
          end
        end
        MAC: begin
          prod <= prod_c;
          acc  <= acc_sat;
          if (idx == LAST) begin
            idx   <= '0;
            state <= ACT;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ACT: begin
          y_q   <= y_next;
          sum_q <= acc;
`ifdef PERCEPTRON_TRAIN_EN
          if (train_q && (target_q != y_next)) begin
            state <= UPDATE;
          end else begin
            y_valid_q <= 1'b1;
            state     <= OUT;
          end
`else
          y_valid_q <= 1'b1;
          state     <= OUT;
`endif
        end
`ifdef PERCEPTRON_TRAIN_EN
        UPDATE: begin
          w_q[idx] <= w_new;
          if (idx == LAST) begin
            idx       <= '0;
            y_valid_q <= 1'b1;
            state     <= OUT;
          end else begin
            idx <= idx + 1'b1;
          end
        end
`endif
        OUT: begin
          if (bus.y_ready_i) begin
            y_valid_q <= 1'b0;
            x_ready_q <= 1'b1;
            busy_q    <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_perceptron_core.sv
// Self-checking bench for perceptron_core: vector table,
// directed corner sequences and randomized runs against a reference model.
module tb_perceptron_core;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int WW = 8;
  localparam int AW = 16;
  localparam int LR = 0;
`ifdef PERCEPTRON_TRAIN_EN
  localparam bit TRAIN = 1'b1;
`else
  localparam bit TRAIN = 1'b0;
`endif

  typedef int vec_t [N];
  typedef struct {
    vec_t x;
    int   hold;
    int   exp_y;
    int   exp_sum;
  } tv_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  perceptron_core_if #(
    .N_INPUTS(N), .DATA_W(DW), .WEIGHT_W(WW), .ACC_W(AW)
  ) bus ();

  perceptron_core #(
    .N_INPUTS(N), .DATA_W(DW), .WEIGHT_W(WW),
    .ACC_W(AW), .LR_SHIFT(LR)
  ) dut (
    .clk_i(clk),
    .reset_i(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int wm [N+1];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int hi, lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Reference: plain arithmetic from the neuron's rules.
  task automatic model(input vec_t x, input int train, input int target,
                       output int y, output int sum, output int lat);
    int acc, err;
    acc = wm[N];
    for (int i = 0; i < N; i++)
      acc = sat(acc + wm[i] * x[i], AW);
    y   = (acc >= 0) ? 1 : 0;
    sum = acc;
    lat = N + 2;
    if (TRAIN && train != 0 && target != y) begin
      err = target - y;
      for (int i = 0; i < N; i++)
        wm[i] = sat(wm[i] + err * (x[i] >>> LR), WW);
      wm[N] = sat(wm[N] + err, WW);
      lat = 2 * N + 3;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i <= N; i++) wm[i] = 0;
  endtask

  task automatic wr(input int addr, input int data);
    @(negedge clk);
    bus.w_wr_i   = 1'b1;
    bus.w_addr_i = 3'(addr);
    bus.w_data_i = WW'(data);
    @(negedge clk);
    bus.w_wr_i = 1'b0;
    if (addr <= N) wm[addr] = sat(data, WW);
  endtask

  task automatic drive_x(input vec_t x);
    logic [N*DW-1:0] xp;
    for (int i = 0; i < N; i++) xp[i*DW +: DW] = DW'(x[i]);
    bus.x_i = xp;
  endtask

  task automatic run_vec(input vec_t x, input int train, input int target,
                         input int hold, input int mac_wr,
                         input int bias_wr, input int bias_val,
                         output int gy, output int gs, output int gl);
    int ey, es, el, n;
    if (bias_wr != 0) wm[N] = sat(bias_val, WW);
    model(x, train, target, ey, es, el);
    @(negedge clk);
    n = 0;
    while (!bus.x_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("x_ready_idle", int'(bus.x_ready_o), 1);
    drive_x(x);
    bus.train_i   = train[0];
    bus.target_i  = target[0];
    bus.x_valid_i = 1'b1;
    if (bias_wr != 0) begin
      bus.w_wr_i   = 1'b1;
      bus.w_addr_i = 3'(N);
      bus.w_data_i = WW'(bias_val);
    end
    @(posedge clk);
    #1;
    bus.x_valid_i = 1'b0;
    bus.w_wr_i    = 1'b0;
    chk("busy_after_accept", int'(bus.busy_o), 1);
    chk("x_ready_busy", int'(bus.x_ready_o), 0);
    if (mac_wr != 0) begin
      bus.w_wr_i   = 1'b1;
      bus.w_addr_i = 3'd0;
      bus.w_data_i = 8'sd99;
    end
    gl = 0;
    while (!bus.y_valid_o && gl < 40) begin
      @(posedge clk);
      #1;
      bus.w_wr_i = 1'b0;
      gl++;
    end
    gy = int'(bus.y_o);
    gs = int'(bus.sum_o);
    chk("latency", gl, el);
    chk("y_o", gy, ey);
    chk("sum_o", gs, es);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", int'(bus.y_valid_o), 1);
      chk("hold_y", int'(bus.y_o), ey);
      chk("hold_sum", int'(bus.sum_o), es);
      chk("hold_x_ready", int'(bus.x_ready_o), 0);
    end
    bus.y_ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.y_ready_i = 1'b0;
    chk("post_valid", int'(bus.y_valid_o), 0);
    chk("post_x_ready", int'(bus.x_ready_o), 1);
    chk("post_busy", int'(bus.busy_o), 0);
    chk("post_sum_kept", int'(bus.sum_o), es);
  endtask

  tv_t tbl [5];

  initial begin
    int gy, gs, gl;
    vec_t v;
    rst           = 1'b1;
    bus.x_valid_i = 1'b0;
    bus.x_i       = '0;
    bus.train_i   = 1'b0;
    bus.target_i  = 1'b0;
    bus.y_ready_i = 1'b0;
    bus.w_wr_i    = 1'b0;
    bus.w_addr_i  = '0;
    bus.w_data_i  = '0;

    tbl[0] = '{x: '{1, 1, 1, 1},         hold: 0, exp_y: 1, exp_sum: 0};
    tbl[1] = '{x: '{-1, 0, 0, 0},        hold: 5, exp_y: 0, exp_sum: -11};
    tbl[2] = '{x: '{5, -5, 2, 0},        hold: 1, exp_y: 0, exp_sum: -9};
    tbl[3] = '{x: '{10, 10, 10, 10},     hold: 0, exp_y: 1, exp_sum: 90};
    tbl[4] = '{x: '{-128, -128, -128, -128}, hold: 2, exp_y: 0,
               exp_sum: -1290};

    do_reset();
    chk("rst_x_ready", int'(bus.x_ready_o), 1);
    chk("rst_y_valid", int'(bus.y_valid_o), 0);
    chk("rst_y", int'(bus.y_o), 0);
    chk("rst_sum", int'(bus.sum_o), 0);
    chk("rst_busy", int'(bus.busy_o), 0);

    wr(0, 1); wr(1, 2); wr(2, 3); wr(3, 4); wr(4, -10);
    for (int t = 0; t < 5; t++) begin
      run_vec(tbl[t].x, 0, 0, tbl[t].hold, 0, 0, 0, gy, gs, gl);
      chk("tbl_y", gy, tbl[t].exp_y);
      chk("tbl_sum", gs, tbl[t].exp_sum);
      chk("tbl_lat", gl, 6);
    end

    // Training from zero weights; latency and second pass depend on build.
    do_reset();
    v = '{2, -3, 0, 1};
    run_vec(v, 1, 0, 0, 0, 0, 0, gy, gs, gl);
    chk("t3_y", gy, 1);
    chk("t3_sum", gs, 0);
    chk("t3_lat", gl, TRAIN ? 11 : 6);
    run_vec(v, 1, 0, 0, 0, 0, 0, gy, gs, gl);
    chk("t3_rep_y", gy, TRAIN ? 0 : 1);
    chk("t3_rep_sum", gs, TRAIN ? -15 : 0);
    chk("t3_rep_lat", gl, 6);

    // Accumulator and weight saturation.
    do_reset();
    for (int i = 0; i < N; i++) wr(i, 127);
    v = '{127, 127, 127, 127};
    run_vec(v, 0, 0, 0, 0, 0, 0, gy, gs, gl);
    chk("sat_sum", gs, 32767);
    for (int k = 0; k < 3; k++)
      run_vec(v, 1, 0, 0, 0, 0, 0, gy, gs, gl);
    do_reset();
    wr(0, -100); wr(1, 127);
    v = '{100, 127, 0, 0};
    run_vec(v, 1, 0, 0, 0, 0, 0, gy, gs, gl);
    v = '{1, 0, 0, 0};
    run_vec(v, 0, 0, 0, 0, 0, 0, gy, gs, gl);
    chk("wsat_probe", gs, TRAIN ? -129 : -100);

    // Write during MAC is dropped; bias write lands with the accept.
    do_reset();
    wr(0, 1); wr(1, 2); wr(2, 3); wr(3, 4);
    v = '{1, 1, 1, 1};
    run_vec(v, 0, 0, 0, 1, 0, 0, gy, gs, gl);
    run_vec(v, 0, 0, 0, 0, 0, 0, gy, gs, gl);
    chk("mac_wr_dropped", gs, 10);
    run_vec(v, 0, 0, 0, 0, 1, 50, gy, gs, gl);
    chk("bias_same_cycle", gs, 60);
    wr(5, 77); wr(6, 77); wr(7, 77);
    run_vec(v, 0, 0, 0, 0, 0, 0, gy, gs, gl);
    chk("addr_ignored", gs, 60);

    // Reset in the middle of MAC.
    @(negedge clk);
    drive_x(v);
    bus.x_valid_i = 1'b1;
    @(posedge clk);
    #1 bus.x_valid_i = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i <= N; i++) wm[i] = 0;
    chk("midrst_busy", int'(bus.busy_o), 0);
    chk("midrst_valid", int'(bus.y_valid_o), 0);
    chk("midrst_x_ready", int'(bus.x_ready_o), 1);
    chk("midrst_sum", int'(bus.sum_o), 0);
    v = '{5, 5, 5, 5};
    run_vec(v, 0, 0, 0, 0, 0, 0, gy, gs, gl);
    chk("midrst_w_clear", gs, 0);

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 2) == 0)
        wr(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)) - 128);
      for (int i = 0; i < N; i++)
        v[i] = int'($urandom_range(0, 255)) - 128;
      run_vec(v, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
              int'($urandom_range(0, 2)), int'($urandom_range(0, 1)),
              0, 0, gy, gs, gl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
